// File: rtl/l1_pkg.sv
// Shared definitions for the L1 instruction-side refill logic: FSM encoding,
// AXI4 field constants and the line-offset width helper.
package l1_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_AR   = 2'd1,
    ST_R    = 2'd2,
    ST_DONE = 2'd3
  } refill_state_e;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  // Ceiling log2; used to size the line offset (bytes per line) and the beat counter.
  function automatic int clog2(input int value);
    int r;
    for (r = 0; (1 << r) < value; r++) begin
    end
    return r;
  endfunction

endpackage

// File: rtl/inst_refill_dma_if.sv
// AXI4 read-address and read-data channels used by the instruction refill DMA.
interface inst_refill_dma_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic [AW-1:0] m_axi_araddr;
  logic [7:0]    m_axi_arlen;
  logic [2:0]    m_axi_arsize;
  logic [1:0]    m_axi_arburst;
  logic          m_axi_arvalid;
  logic          m_axi_arready;
  logic [DW-1:0] m_axi_rdata;
  logic [1:0]    m_axi_rresp;
  logic          m_axi_rlast;
  logic          m_axi_rvalid;
  logic          m_axi_rready;

  modport master (
    output m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arvalid,
    input  m_axi_arready,
    input  m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
    output m_axi_rready
  );

  modport slave (
    input  m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arvalid,
    output m_axi_arready,
    output m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
    input  m_axi_rready
  );
endinterface

// File: rtl/inst_refill_dma.sv
// Instruction refill DMA: one AXI4 INCR read burst per miss, each beat written
// into the instruction memory, then a one-cycle done pulse with sticky error.
module inst_refill_dma
  import l1_pkg::*;
#(
  parameter int INST_WIDTH      = 32,
  parameter int INST_ADDR_WIDTH = 32,
  parameter int READ_BURST_LEN  = 8
) (
  input  logic                       cpu_clk,
  input  logic                       cpu_rst_n,
  input  logic                       refill_req,
  input  logic [INST_ADDR_WIDTH-1:0] refill_addr,
  output logic                       refill_busy,
  output logic                       refill_done,
  output logic                       refill_err,
  output logic [INST_ADDR_WIDTH-1:0] dma_inst_mem_waddr,
  output logic [INST_WIDTH-1:0]      dma_inst_mem_wdata,
  output logic                       inst_mem_write,
  inst_refill_dma_if.master          axi
);

  localparam int AW    = INST_ADDR_WIDTH;
  localparam int OFF_W = clog2(READ_BURST_LEN * 4);
  localparam int CNT_W = (READ_BURST_LEN > 1) ? clog2(READ_BURST_LEN) : 1;

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(READ_BURST_LEN - 1);
  localparam logic [AW-1:0]    OFF_MASK  = AW'((64'd1 << OFF_W) - 64'd1);

  refill_state_e           state_q, state_d;
  logic [AW-1:0]           base_q, base_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    err_q, err_d;
  logic [AW-1:0]           waddr_q, waddr_d;
  logic [INST_WIDTH-1:0]   wdata_q, wdata_d;
  logic                    write_q, write_d;
  logic                    is_last;

  assign is_last = (cnt_q == LAST_BEAT);

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    write_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (refill_req) begin
          base_d  = refill_addr & ~OFF_MASK;
          cnt_d   = '0;
          err_d   = 1'b0;
          state_d = ST_AR;
        end
      end
      ST_AR: begin
        if (axi.m_axi_arready) state_d = ST_R;
      end
      ST_R: begin
        // The burst ends on beat count alone; a wrong RLAST only flags an error.
        if (axi.m_axi_rvalid) begin
          wdata_d = axi.m_axi_rdata;
          waddr_d = base_q + (AW'(cnt_q) << 2);
          write_d = 1'b1;
          cnt_d   = cnt_q + CNT_W'(1);
          if ((axi.m_axi_rresp != AXI_RESP_OKAY) || (axi.m_axi_rlast != is_last)) err_d = 1'b1;
          if (is_last) state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      state_q <= ST_IDLE;
      base_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      write_q <= write_d;
    end
  end

  assign refill_busy        = (state_q != ST_IDLE);
  assign refill_done        = (state_q == ST_DONE);
  assign refill_err         = (state_q == ST_DONE) && err_q;
  assign dma_inst_mem_waddr = waddr_q;
  assign dma_inst_mem_wdata = wdata_q;
  assign inst_mem_write     = write_q;

  assign axi.m_axi_araddr   = base_q;
  assign axi.m_axi_arlen    = 8'(READ_BURST_LEN - 1);
  assign axi.m_axi_arsize   = AXI_SIZE_4B;
  assign axi.m_axi_arburst  = AXI_BURST_INCR;
  assign axi.m_axi_arvalid  = (state_q == ST_AR);
  assign axi.m_axi_rready   = (state_q == ST_R);

endmodule

// File: tb/tb_inst_refill_dma.sv
// Directed bench for inst_refill_dma: a cycle-stepped AXI read slave and
// scenario tasks with hand-computed expectations.
module tb_inst_refill_dma;

  localparam int LEN = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        refill_req = 1'b0;
  logic [31:0] refill_addr = '0;
  logic        refill_busy, refill_done, refill_err, inst_mem_write;
  logic [31:0] waddr, wdata;

  int errors = 0;
  int checks = 0;

  inst_refill_dma_if #(.AW(32), .DW(32)) ifc ();

  inst_refill_dma #(
    .INST_WIDTH(32), .INST_ADDR_WIDTH(32), .READ_BURST_LEN(LEN)
  ) dut (
    .cpu_clk(clk), .cpu_rst_n(rst_n),
    .refill_req(refill_req), .refill_addr(refill_addr),
    .refill_busy(refill_busy), .refill_done(refill_done), .refill_err(refill_err),
    .dma_inst_mem_waddr(waddr), .dma_inst_mem_wdata(wdata),
    .inst_mem_write(inst_mem_write),
    .axi(ifc.master)
  );

  always #5 clk = ~clk;

  // Observations collected by run_refill
  int          n_wr, done_cyc, ar_cycles, beats;
  logic [31:0] wr_addr [16];
  logic [31:0] wr_data [16];
  logic        done_err, ar_unstable, r_in_ar, wr_in_gap;
  logic [31:0] ar_addr;

  // gap_mode 1: rvalid pattern 1,0,0 repeating. last_mode 0: rlast on beat 7,
  // 1: rlast on beats 5 and 7, 2: rlast never.
  task automatic run_refill(input logic [31:0] addr, input int ar_delay, input int gap_mode,
                            input int err_beat, input int last_mode, input bit keep_req);
    logic acc_prev;
    int   rk;
    n_wr = 0; done_cyc = -1; done_err = 1'b0; ar_cycles = 0; ar_unstable = 1'b0;
    r_in_ar = 1'b0; wr_in_gap = 1'b0; beats = 0; acc_prev = 1'b0; rk = 0; ar_addr = '0;
    for (int i = 0; i < 16; i++) begin wr_addr[i] = 'x; wr_data[i] = 'x; end
    @(negedge clk);
    refill_req = 1'b1; refill_addr = addr;
    ifc.m_axi_arready = 1'b0; ifc.m_axi_rvalid = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (!keep_req) begin
        refill_req = 1'b0;
        refill_addr = addr ^ 32'hFFFF_0000;
      end
      if (ifc.m_axi_arvalid) begin
        if (ar_cycles > 0 && ifc.m_axi_araddr !== ar_addr) ar_unstable = 1'b1;
        ar_addr = ifc.m_axi_araddr;
        ar_cycles++;
        if (ifc.m_axi_rready) r_in_ar = 1'b1;
      end
      if (inst_mem_write) begin
        if (!acc_prev) wr_in_gap = 1'b1;
        if (n_wr < 16) begin wr_addr[n_wr] = waddr; wr_data[n_wr] = wdata; end
        n_wr++;
      end
      if (refill_done) begin done_cyc = c; done_err = refill_err; end
      ifc.m_axi_arready = (c > ar_delay);
      acc_prev = 1'b0;
      ifc.m_axi_rvalid = 1'b0; ifc.m_axi_rlast = 1'b0; ifc.m_axi_rresp = 2'b00;
      ifc.m_axi_rdata = 32'hDEAD_BEEF;
      if (ifc.m_axi_rready) begin
        if (gap_mode == 0 || (rk % 3) == 0) begin
          ifc.m_axi_rvalid = 1'b1;
          ifc.m_axi_rdata  = 32'(32'hA0 + beats);
          ifc.m_axi_rresp  = (beats == err_beat) ? 2'b10 : 2'b00;
          case (last_mode)
            0:       ifc.m_axi_rlast = (beats == LEN - 1);
            1:       ifc.m_axi_rlast = (beats == 5) || (beats == LEN - 1);
            default: ifc.m_axi_rlast = 1'b0;
          endcase
          acc_prev = 1'b1;
          beats++;
        end
        rk++;
      end
      if (refill_done) break;
    end
    ifc.m_axi_arready = 1'b0; ifc.m_axi_rvalid = 1'b0; ifc.m_axi_rlast = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ifc.m_axi_arready = 1'b0; ifc.m_axi_rvalid = 1'b0; ifc.m_axi_rlast = 1'b0;
    ifc.m_axi_rresp = 2'b00; ifc.m_axi_rdata = '0;
    repeat (2) @(negedge clk);
    checks++; if ({refill_busy, refill_done, refill_err, inst_mem_write, ifc.m_axi_arvalid, ifc.m_axi_rready} !== 6'b0) begin
      errors++; $display("FAIL reset_ctrl got=%b want=000000", {refill_busy, refill_done, refill_err, inst_mem_write, ifc.m_axi_arvalid, ifc.m_axi_rready}); end
    checks++; if (waddr !== 32'h0) begin errors++; $display("FAIL reset_waddr got=%h want=0", waddr); end
    checks++; if (wdata !== 32'h0) begin errors++; $display("FAIL reset_wdata got=%h want=0", wdata); end
    checks++; if (ifc.m_axi_araddr !== 32'h0) begin errors++; $display("FAIL reset_araddr got=%h want=0", ifc.m_axi_araddr); end
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    run_refill(32'h0000_0124, 0, 0, -1, 0, 1'b0);
    checks++; if (ar_addr !== 32'h0000_0120) begin errors++; $display("FAIL basic_araddr got=%h want=00000120", ar_addr); end
    checks++; if (ifc.m_axi_arlen !== 8'd7) begin errors++; $display("FAIL basic_arlen got=%0d want=7", ifc.m_axi_arlen); end
    checks++; if ({ifc.m_axi_arsize, ifc.m_axi_arburst} !== 5'b010_01) begin errors++; $display("FAIL basic_arsize_burst got=%b want=01001", {ifc.m_axi_arsize, ifc.m_axi_arburst}); end
    checks++; if (ar_cycles !== 1) begin errors++; $display("FAIL basic_ar_cycles got=%0d want=1", ar_cycles); end
    checks++; if (done_cyc !== 10) begin errors++; $display("FAIL basic_done_cycle got=%0d want=10", done_cyc); end
    checks++; if (done_err !== 1'b0) begin errors++; $display("FAIL basic_err got=%b want=0", done_err); end
    checks++; if (n_wr !== 8) begin errors++; $display("FAIL basic_writes got=%0d want=8", n_wr); end
    checks++; if (wr_in_gap !== 1'b0) begin errors++; $display("FAIL basic_stray_write got=%b want=0", wr_in_gap); end
    for (int i = 0; i < LEN; i++) begin
      checks++; if (wr_addr[i] !== 32'(32'h120 + 4*i)) begin errors++; $display("FAIL basic_waddr[%0d] got=%h want=%h", i, wr_addr[i], 32'(32'h120 + 4*i)); end
      checks++; if (wr_data[i] !== 32'(32'hA0 + i)) begin errors++; $display("FAIL basic_wdata[%0d] got=%h want=%h", i, wr_data[i], 32'(32'hA0 + i)); end
    end
  endtask

  task automatic test_ar_backpressure();
    run_refill(32'h0000_1FFC, 5, 0, -1, 0, 1'b0);
    checks++; if (ar_cycles !== 6) begin errors++; $display("FAIL arbp_ar_cycles got=%0d want=6", ar_cycles); end
    checks++; if (ar_unstable !== 1'b0) begin errors++; $display("FAIL arbp_araddr_stable got=%b want=0", ar_unstable); end
    checks++; if (ar_addr !== 32'h0000_1FE0) begin errors++; $display("FAIL arbp_araddr got=%h want=00001fe0", ar_addr); end
    checks++; if (r_in_ar !== 1'b0) begin errors++; $display("FAIL arbp_rready_in_ar got=%b want=0", r_in_ar); end
    checks++; if (done_cyc !== 15) begin errors++; $display("FAIL arbp_done_cycle got=%0d want=15", done_cyc); end
    checks++; if (n_wr !== 8) begin errors++; $display("FAIL arbp_writes got=%0d want=8", n_wr); end
    checks++; if (wr_addr[7] !== 32'h0000_1FFC) begin errors++; $display("FAIL arbp_last_waddr got=%h want=00001ffc", wr_addr[7]); end
  endtask

  task automatic test_rvalid_gaps();
    run_refill(32'h0000_0040, 0, 1, -1, 0, 1'b0);
    checks++; if (n_wr !== 8) begin errors++; $display("FAIL gaps_writes got=%0d want=8", n_wr); end
    checks++; if (wr_in_gap !== 1'b0) begin errors++; $display("FAIL gaps_write_in_gap got=%b want=0", wr_in_gap); end
    checks++; if (done_cyc !== 24) begin errors++; $display("FAIL gaps_done_cycle got=%0d want=24", done_cyc); end
    checks++; if (done_err !== 1'b0) begin errors++; $display("FAIL gaps_err got=%b want=0", done_err); end
    for (int i = 0; i < LEN; i++) begin
      checks++; if (wr_addr[i] !== 32'(32'h40 + 4*i) || wr_data[i] !== 32'(32'hA0 + i)) begin
        errors++; $display("FAIL gaps_beat[%0d] got=%h/%h want=%h/%h", i, wr_addr[i], wr_data[i], 32'(32'h40 + 4*i), 32'(32'hA0 + i)); end
    end
  endtask

  task automatic test_err_resp();
    run_refill(32'h0000_0200, 0, 0, 3, 0, 1'b0);
    checks++; if (n_wr !== 8) begin errors++; $display("FAIL errresp_writes got=%0d want=8", n_wr); end
    checks++; if (done_err !== 1'b1) begin errors++; $display("FAIL errresp_err got=%b want=1", done_err); end
    checks++; if (done_cyc !== 10) begin errors++; $display("FAIL errresp_done_cycle got=%0d want=10", done_cyc); end
    run_refill(32'h0000_0300, 0, 0, -1, 0, 1'b0);
    checks++; if (done_err !== 1'b0) begin errors++; $display("FAIL errresp_clean_err got=%b want=0", done_err); end
    checks++; if (wr_addr[0] !== 32'h0000_0300) begin errors++; $display("FAIL errresp_clean_waddr got=%h want=00000300", wr_addr[0]); end
  endtask

  task automatic test_rlast_mismatch();
    run_refill(32'h0000_0400, 0, 0, -1, 1, 1'b0);
    checks++; if (beats !== 8) begin errors++; $display("FAIL early_rlast_beats got=%0d want=8", beats); end
    checks++; if (n_wr !== 8) begin errors++; $display("FAIL early_rlast_writes got=%0d want=8", n_wr); end
    checks++; if (done_err !== 1'b1) begin errors++; $display("FAIL early_rlast_err got=%b want=1", done_err); end
    checks++; if (done_cyc !== 10) begin errors++; $display("FAIL early_rlast_done_cycle got=%0d want=10", done_cyc); end
    run_refill(32'h0000_0500, 0, 0, -1, 2, 1'b0);
    checks++; if (done_err !== 1'b1) begin errors++; $display("FAIL missing_rlast_err got=%b want=1", done_err); end
    checks++; if (done_cyc !== 10) begin errors++; $display("FAIL missing_rlast_done_cycle got=%0d want=10", done_cyc); end
  endtask

  task automatic test_back_to_back();
    run_refill(32'h8000_0004, 0, 0, -1, 0, 1'b1);
    checks++; if (done_cyc !== 10) begin errors++; $display("FAIL b2b_done_cycle got=%0d want=10", done_cyc); end
    @(negedge clk);
    checks++; if (refill_busy !== 1'b0) begin errors++; $display("FAIL b2b_idle_gap got=%b want=0", refill_busy); end
    @(negedge clk);
    checks++; if (ifc.m_axi_arvalid !== 1'b1 || ifc.m_axi_araddr !== 32'h8000_0000) begin
      errors++; $display("FAIL b2b_restart got=%b/%h want=1/80000000", ifc.m_axi_arvalid, ifc.m_axi_araddr); end
    refill_req = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset_mid();
    int  nw;
    logic saw_done;
    nw = 0; saw_done = 1'b0;
    @(negedge clk);
    refill_req = 1'b1; refill_addr = 32'h0000_0A10;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      refill_req = 1'b0;
      ifc.m_axi_arready = 1'b1;
      if (inst_mem_write) nw++;
      if (nw == 4) break;
      ifc.m_axi_rvalid = ifc.m_axi_rready;
      ifc.m_axi_rdata  = 32'(32'hB0 + c);
      ifc.m_axi_rlast  = 1'b0;
    end
    ifc.m_axi_rvalid = 1'b0; ifc.m_axi_arready = 1'b0;
    checks++; if (nw !== 4) begin errors++; $display("FAIL rstmid_pre_writes got=%0d want=4", nw); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({refill_busy, refill_done, refill_err, inst_mem_write, ifc.m_axi_arvalid, ifc.m_axi_rready} !== 6'b0) begin
      errors++; $display("FAIL rstmid_ctrl got=%b want=000000", {refill_busy, refill_done, refill_err, inst_mem_write, ifc.m_axi_arvalid, ifc.m_axi_rready}); end
    checks++; if ({waddr, wdata, ifc.m_axi_araddr} !== 96'h0) begin
      errors++; $display("FAIL rstmid_data got=%h/%h/%h want=0/0/0", waddr, wdata, ifc.m_axi_araddr); end
    repeat (3) begin
      @(negedge clk);
      if (refill_done) saw_done = 1'b1;
    end
    checks++; if (saw_done !== 1'b0) begin errors++; $display("FAIL rstmid_done_pulse got=%b want=0", saw_done); end
    rst_n = 1'b1;
    run_refill(32'h0000_0A10, 0, 0, -1, 0, 1'b0);
    checks++; if (done_cyc !== 10 || done_err !== 1'b0) begin errors++; $display("FAIL rstmid_after_done got=%0d/%b want=10/0", done_cyc, done_err); end
    checks++; if (n_wr !== 8) begin errors++; $display("FAIL rstmid_after_writes got=%0d want=8", n_wr); end
    for (int i = 0; i < LEN; i++) begin
      checks++; if (wr_addr[i] !== 32'(32'hA00 + 4*i) || wr_data[i] !== 32'(32'hA0 + i)) begin
        errors++; $display("FAIL rstmid_after_beat[%0d] got=%h/%h want=%h/%h", i, wr_addr[i], wr_data[i], 32'(32'hA00 + 4*i), 32'(32'hA0 + i)); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ar_backpressure();
    test_rvalid_gaps();
    test_err_resp();
    test_rlast_mismatch();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
